// File: rtl/serial_comparator_ctrl.sv
// -----------------------------------------------------------------------------
// serial_comparator_ctrl
//
// Bit-serial magnitude comparator sequencer. Two WIDTH-bit unsigned operands
// are latched when a compare is accepted. They are then compared MSB-first,
// one bit per clock. The compare stops at the first differing bit, or after
// the LSB when the operands are equal. A start/busy/done handshake and
// registered one-hot result flags are presented to the surrounding logic.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high, highest priority
//   start    compare request, accepted only while idle
//   a_in     operand A, sampled on the accepting edge only
//   b_in     operand B, sampled on the accepting edge only
//   busy     high from the accepting edge through the done cycle
//   done     single-cycle pulse, results valid
//   lesser   A < B
//   greater  A > B
//   equal    A == B
//   cycles   number of bit-compare cycles used by the last operation
// -----------------------------------------------------------------------------
module serial_comparator_ctrl #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             lesser,
    output logic             greater,
    output logic             equal,
    output logic [CW-1:0]    cycles
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lesser_q, lesser_d;
    logic             greater_q, greater_d;
    logic             equal_q, equal_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        lesser_d  = lesser_q;
        greater_d = greater_q;
        equal_d   = equal_q;
        cycles_d  = cycles_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    idx_d     = IW'(WIDTH - 1);
                    lesser_d  = 1'b0;
                    greater_d = 1'b0;
                    equal_d   = 1'b0;
                    cycles_d  = {CW{1'b0}};
                    state_d   = COMPARE;
                end else begin
                    state_d   = IDLE;
                end
            end
            COMPARE: begin
                cycles_d = cycles_q + CW'(1);
                if (a_q[idx_q] && !b_q[idx_q]) begin
                    greater_d = 1'b1;
                    state_d   = DONE;
                end else if (!a_q[idx_q] && b_q[idx_q]) begin
                    lesser_d  = 1'b1;
                    state_d   = DONE;
                end else if (idx_q == {IW{1'b0}}) begin
                    equal_d   = 1'b1;
                    state_d   = DONE;
                end else begin
                    idx_d     = idx_q - IW'(1);
                    state_d   = COMPARE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here; the next request
                // can only be taken in the IDLE cycle that follows.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy/done are registered copies of where the FSM is heading, so they
        // line up with the state register without any output decode glitches.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, operand and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            idx_q     <= {IW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lesser_q  <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
            cycles_q  <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            lesser_q  <= lesser_d;
            greater_q <= greater_d;
            equal_q   <= equal_d;
            cycles_q  <= cycles_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign lesser  = lesser_q;
    assign greater = greater_q;
    assign equal   = equal_q;
    assign cycles  = cycles_q;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for serial_comparator_ctrl (WIDTH = 4).
// The expected results come from plain arithmetic on the operands: relational
// operators give the flags, and the highest set bit of a^b gives the cycle count.
// -----------------------------------------------------------------------------
module tb_serial_comparator_ctrl;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             lesser;
    logic             greater;
    logic             equal;
    logic [CW-1:0]    cycles;

    int vectors     = 0;
    int miscompares = 0;

    serial_comparator_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .lesser  (lesser),
        .greater (greater),
        .equal   (equal),
        .cycles  (cycles)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: flags by relational operators, n by the highest differing bit.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic lt, output logic gt, output logic eq,
                         output int n);
        logic [WIDTH-1:0] x;
        int k;
        lt = (a < b);
        gt = (a > b);
        eq = (a == b);
        x  = a ^ b;
        k  = -1;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) k = i;
        end
        n = (k < 0) ? WIDTH : (WIDTH - k);
    endtask

    // Present operands with start in an IDLE cycle and check the acceptance.
    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit hold);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = hold;
        a_in  = WIDTH'($urandom);
        b_in  = WIDTH'($urandom);
        chk("acc_busy",  busy, 32'd1);
        chk("acc_done",  done, 32'd0);
        chk("acc_flags", {lesser, greater, equal}, 32'd0);
        chk("acc_cycles", cycles, 32'd0);
    endtask

    // Wait (bounded) for done and check latency, flags and the return to idle.
    // With hold set, start stays high on junk operands throughout.
    task automatic finish(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit hold);
        logic lt, gt, eq;
        int   n;
        int   lat;
        model(a, b, lt, gt, eq, n);
        lat = 0;
        for (int t = 1; t <= WIDTH + 2; t++) begin
            tick();
            lat = t;
            if (hold) begin
                a_in = WIDTH'($urandom);
                b_in = WIDTH'($urandom);
            end
            if (done) break;
        end
        chk("latency",   lat, n);
        chk("done_busy", busy, 32'd1);
        chk("flags",     {lesser, greater, equal}, {29'd0, lt, gt, eq});
        chk("cycles",    cycles, n);
        tick();
        chk("post_done", done, 32'd0);
        chk("post_busy", busy, 32'd0);
        chk("hold_flags", {lesser, greater, equal}, {29'd0, lt, gt, eq});
        chk("hold_cycles", cycles, n);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        bit               rh;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = 4'b0000;
        b_in  = 4'b0000;
        tick();
        tick();
        chk("rst_busy",   busy, 32'd0);
        chk("rst_done",   done, 32'd0);
        chk("rst_flags",  {lesser, greater, equal}, 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 32'd0);

        // MSBs differ: shortest compare
        accept(4'b1010, 4'b0101, 1'b0);
        finish(4'b1010, 4'b0101, 1'b0);

        // Differ only at the LSB
        accept(4'b0110, 4'b0111, 1'b0);
        finish(4'b0110, 4'b0111, 1'b0);

        // Equal operands
        accept(4'b1001, 4'b1001, 1'b0);
        finish(4'b1001, 4'b1001, 1'b0);

        // start held high with changing operands while busy; the next
        // acceptance happens in IDLE with the operands presented then.
        accept(4'b0011, 4'b0010, 1'b1);
        finish(4'b0011, 4'b0010, 1'b1);
        accept(4'b1100, 4'b1110, 1'b0);
        finish(4'b1100, 4'b1110, 1'b0);

        // Reset in the second COMPARE cycle aborts the operation
        accept(4'b0001, 4'b0000, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",   busy, 32'd0);
        chk("abort_done",   done, 32'd0);
        chk("abort_flags",  {lesser, greater, equal}, 32'd0);
        chk("abort_cycles", cycles, 32'd0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            chk("abort_nodone", done, 32'd0);
        end
        accept(4'b0001, 4'b0000, 1'b0);
        finish(4'b0001, 4'b0000, 1'b0);

        // Every operand pair, back to back
        for (int i = 0; i < 256; i++) begin
            ra = WIDTH'(i >> 4);
            rb = WIDTH'(i);
            accept(ra, rb, 1'b0);
            finish(ra, rb, 1'b0);
        end

        // Random pairs, with start randomly held high during busy
        for (int i = 0; i < 60; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rh = 1'($urandom);
            accept(ra, rb, rh);
            finish(ra, rb, rh);
            if (!rh && $urandom_range(0, 1) == 0) begin
                tick();
                chk("idle_gap_busy", busy, 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
